tt_aes_pin_bridge: RTL and testbench
====================================

Name: tt_aes_pin_bridge

Overview:
- Parametrised pin-level bridge between the TinyTapeout pad interface and the AES core's byte-stream bus.
- Replaces tied-off command fields with a host-loaded header: opcode, source_id, dest_id, encdec, addr and payload length.
- Buffers host-to-core bytes and core-to-host bytes in independent FIFOs.
- Synchronises asynchronous host strobes and runs a framed transfer state machine, with completion and error status returned on pins.

Parameters:
DATA_W, 8, pin/core byte width; ADDR_W must be a multiple of it
ADDR_W, 24, width of addr field; header carries ADDR_W/DATA_W address bytes, MSB first
IN_DEPTH, 4, host->core FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, core->host FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 1024, idle-cycle limit in STREAM (used only with AES_BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pin_data_in  in  DATA_W  host byte; stable while pin_strobe high
pin_strobe  in  1  async; rising edge = host presents byte
pin_rd  in  1  async; rising edge = host consumed pin_data_out
pin_data_out  out  DATA_W  head of out FIFO (0 when empty)
pin_status  out  4  {err, done, out_valid, in_full}
core_data_in  out  DATA_W  byte to AES
core_valid_in  out  1  byte valid to AES
core_ready_in  in  1  AES accepts byte
core_data_out  in  DATA_W  byte from AES
core_data_valid  in  1  AES byte valid
core_data_ready  out  1  bridge accepts AES byte
core_ack_valid  in  1  AES operation complete
core_ack_ready  out  1  bridge accepts ack
opcode  out  2  header field
source_id  out  2  header field
dest_id  out  2  header field
encdec  out  1  header field
addr  out  ADDR_W  header field

Behaviour:
- Reset: clk, rst synchronous active-high. Clears FIFOs, sync flops, FSM to IDLE, header regs, len and count. All outputs 0, except core_data_ready=1 (out FIFO empty).
- Strobe sync: pin_strobe and pin_rd each pass through 2 flops plus an edge register; one event per rising edge. An event is acted on 3 clk after the pin edge, sampling pin_data_in in that cycle.
- Header byte 0 layout: {opcode[7:6], source_id[5:4], dest_id[3:2], encdec[1], rsvd[0]}. Then ADDR_W/DATA_W address bytes, MSB first. Then 1 length byte L; payload length = L+1 (1..256).
- IDLE: strobe event -> load byte 0, clear err and done, go HDR.
- HDR: each strobe event loads the next header field. After the length byte, count=0 and go STREAM. Header outputs hold from the end of HDR until the next IDLE strobe event.
- STREAM, host side: strobe event pushes pin_data_in into the in FIFO.
  - If the FIFO is full, the byte is dropped and err is set.
  - Bytes beyond L+1 pushed are dropped and set err.
- STREAM, core side: core_valid_in = in FIFO non-empty; core_data_in = FIFO head. Pop on core_valid_in && core_ready_in; count++.
  - When count reaches L+1 after a pop -> WAIT_ACK.
- WAIT_ACK: core_ack_ready=1. core_ack_valid -> done=1, go IDLE. Strobe events here are dropped and set err.
- Out FIFO (independent of FSM): core_data_ready = !out_full; push on core_data_valid && core_data_ready.
  - pin_data_out = head; out_valid = !out_empty.
  - pin_rd event pops; pin_rd event when empty is ignored.
  - Simultaneous push and pop is legal in any occupancy (count unchanged when full).
- in_full = in FIFO full. err and done are sticky until the next IDLE strobe event or rst.
- Both FIFOs support simultaneous push and pop, including when full.
- rst mid-frame aborts everything; bytes in flight are discarded and no ack is expected.

Optional Feature:
- Macro AES_BRIDGE_TIMEOUT_EN.
- Defined: a cycle counter runs in STREAM and WAIT_ACK. It resets on any strobe event, core pop or ack. On reaching TIMEOUT_CYC, set err, flush the in FIFO and go IDLE; header outputs hold.
- Not defined: no counter; STREAM and WAIT_ACK wait indefinitely.

Test Plan:
- Reset: assert rst 2 cycles -> pin_status=0, core_valid_in=0, core_ack_ready=0, core_data_ready=1, addr=0.
- Frame: strobe 0xC8,0x12,0x34,0x56,0x02 then 0x11,0x22,0x33, core_ready_in=1 -> opcode=3, source_id=0, dest_id=2, encdec=0, addr=0x123456. Core receives 0x11,0x22,0x33 in order; enters WAIT_ACK; core_ack_valid pulse -> done=1, IDLE.
- Backpressure: core_ready_in=0, L=0x07, strobe 5 bytes with IN_DEPTH=4 -> in_full=1 after 4th, 5th dropped, err=1. Releasing ready drains 4 bytes, and the FSM stays in STREAM.
- Out FIFO: core pushes 0xA1,0xA2 -> pin_data_out=0xA1, out_valid=1. pin_rd -> 0xA2; pin_rd -> out_valid=0; extra pin_rd ignored. Pushing 4 bytes -> core_data_ready=0.
- Reset mid-STREAM after 2 of 4 payload bytes -> all state cleared. A new frame then completes normally with err=0.
- With AES_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16: stall host in STREAM 16 cycles -> err=1, in FIFO empty, FSM IDLE. Without the macro, the same stall leaves the FSM in STREAM with err=0.

Source files
------------

// File: rtl/tt_aes_pin_bridge.sv
// TinyTapeout pad <-> AES byte-stream bridge: header loader, framed transfer FSM, in/out FIFOs.
// Optional idle timeout in STREAM/WAIT_ACK is enabled by defining AES_BRIDGE_TIMEOUT_EN.

module tt_aes_pin_bridge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
            else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

module tt_aes_pin_bridge #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 24,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pin_data_in,
    input  logic              pin_strobe,
    input  logic              pin_rd,
    output logic [DATA_W-1:0] pin_data_out,
    output logic [3:0]        pin_status,
    output logic [DATA_W-1:0] core_data_in,
    output logic              core_valid_in,
    input  logic              core_ready_in,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_data_valid,
    output logic              core_data_ready,
    input  logic              core_ack_valid,
    output logic              core_ack_ready,
    output logic [1:0]        opcode,
    output logic [1:0]        source_id,
    output logic [1:0]        dest_id,
    output logic              encdec,
    output logic [ADDR_W-1:0] addr
);
    localparam int ADDR_BYTES = ADDR_W / DATA_W;
    localparam int HIDX_W     = $clog2(ADDR_BYTES + 1);
    localparam int CNT_W      = DATA_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_STREAM, S_WAIT_ACK} state_t;

    // Two-flop synchroniser plus edge register per async pin; bit 0 strobe, bit 1 rd.
    logic [1:0] async_pins;
    logic [1:0] pin_evt;
    assign async_pins = {pin_rd, pin_strobe};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q, sync_q, prev_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    meta_q <= async_pins[gi];
                    sync_q <= meta_q;
                    prev_q <= sync_q;
                end
            end
            assign pin_evt[gi] = sync_q && !prev_q;
        end
    endgenerate

    logic strb_evt, rd_evt;
    assign strb_evt = pin_evt[0];
    assign rd_evt   = pin_evt[1];

    state_t              state_q, state_d;
    logic [HIDX_W-1:0]   hdr_idx_q, hdr_idx_d;
    logic [1:0]          opcode_q, opcode_d;
    logic [1:0]          source_q, source_d;
    logic [1:0]          dest_q, dest_d;
    logic                encdec_q, encdec_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    pushed_q, pushed_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    len_plus1;

    logic                in_push, in_pop, in_flush, in_full, in_empty;
    logic [DATA_W-1:0]   in_head;
    logic                out_full, out_empty;
    logic [DATA_W-1:0]   out_head;

    assign len_plus1 = {1'b0, len_q} + CNT_W'(1);
    assign in_pop    = core_valid_in && core_ready_in;

`ifdef AES_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        opcode_d  = opcode_q;
        source_d  = source_q;
        dest_d    = dest_q;
        encdec_d  = encdec_q;
        addr_d    = addr_q;
        len_d     = len_q;
        count_d   = count_q;
        pushed_d  = pushed_q;
        err_d     = err_q;
        done_d    = done_q;
        in_push   = 1'b0;
        in_flush  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strb_evt) begin
                    opcode_d  = pin_data_in[7:6];
                    source_d  = pin_data_in[5:4];
                    dest_d    = pin_data_in[3:2];
                    encdec_d  = pin_data_in[1];
                    err_d     = 1'b0;
                    done_d    = 1'b0;
                    hdr_idx_d = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (strb_evt) begin
                    if (hdr_idx_q != HIDX_W'(ADDR_BYTES)) begin
                        // Address arrives MSB first, so shift the older bytes up.
                        addr_d    = (addr_q << DATA_W) | ADDR_W'(pin_data_in);
                        hdr_idx_d = hdr_idx_q + HIDX_W'(1);
                    end else begin
                        len_d    = pin_data_in;
                        count_d  = '0;
                        pushed_d = '0;
                        state_d  = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (strb_evt) begin
                    if (pushed_q == len_plus1 || (in_full && !in_pop)) begin
                        err_d = 1'b1;
                    end else begin
                        in_push  = 1'b1;
                        pushed_d = pushed_q + CNT_W'(1);
                    end
                end
                if (in_pop) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == len_plus1) state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (strb_evt) err_d = 1'b1;
                if (core_ack_valid) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AES_BRIDGE_TIMEOUT_EN
        timer_d = '0;
        if (state_q == S_STREAM || state_q == S_WAIT_ACK) begin
            if (strb_evt || in_pop || core_ack_valid) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                // Abandon the frame but leave the header outputs as they were.
                err_d    = 1'b1;
                in_flush = 1'b1;
                state_d  = S_IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_idx_q <= '0;
            opcode_q  <= '0;
            source_q  <= '0;
            dest_q    <= '0;
            encdec_q  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            pushed_q  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            opcode_q  <= opcode_d;
            source_q  <= source_d;
            dest_q    <= dest_d;
            encdec_q  <= encdec_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            count_q   <= count_d;
            pushed_q  <= pushed_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

`ifdef AES_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`endif

    tt_aes_pin_bridge_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (in_flush),
        .push    (in_push),
        .wr_data (pin_data_in),
        .pop     (in_pop),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty)
    );

    tt_aes_pin_bridge_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (1'b0),
        .push    (core_data_valid && core_data_ready),
        .wr_data (core_data_out),
        .pop     (rd_evt),
        .rd_data (out_head),
        .full    (out_full),
        .empty   (out_empty)
    );

    assign core_valid_in   = !in_empty;
    assign core_data_in    = in_empty ? '0 : in_head;
    assign core_data_ready = !out_full;
    assign core_ack_ready  = (state_q == S_WAIT_ACK);
    assign pin_data_out    = out_empty ? '0 : out_head;
    assign pin_status      = {err_q, done_q, !out_empty, in_full};

    assign opcode    = opcode_q;
    assign source_id = source_q;
    assign dest_id   = dest_q;
    assign encdec    = encdec_q;
    assign addr      = addr_q;
endmodule

// File: tb/tb_tt_aes_pin_bridge.sv
// Self-checking bench for tt_aes_pin_bridge: directed scenarios plus randomized frames and
// out-FIFO traffic checked against a queue-based reference model.
module tb_tt_aes_pin_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pin_data_in;
    logic        pin_strobe;
    logic        pin_rd;
    logic [7:0]  pin_data_out;
    logic [3:0]  pin_status;
    logic [7:0]  core_data_in;
    logic        core_valid_in;
    logic        core_ready_in;
    logic [7:0]  core_data_out;
    logic        core_data_valid;
    logic        core_data_ready;
    logic        core_ack_valid;
    logic        core_ack_ready;
    logic [1:0]  opcode, source_id, dest_id;
    logic        encdec;
    logic [23:0] addr;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] core_rx[$];

    always #5 clk = ~clk;

    tt_aes_pin_bridge #(
        .DATA_W(8), .ADDR_W(24), .IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .pin_data_in(pin_data_in), .pin_strobe(pin_strobe), .pin_rd(pin_rd),
        .pin_data_out(pin_data_out), .pin_status(pin_status),
        .core_data_in(core_data_in), .core_valid_in(core_valid_in),
        .core_ready_in(core_ready_in), .core_data_out(core_data_out),
        .core_data_valid(core_data_valid), .core_data_ready(core_data_ready),
        .core_ack_valid(core_ack_valid), .core_ack_ready(core_ack_ready),
        .opcode(opcode), .source_id(source_id), .dest_id(dest_id),
        .encdec(encdec), .addr(addr)
    );

    // Capture every byte the core actually takes.
    always @(posedge clk) begin
        if (!rst && core_valid_in && core_ready_in) core_rx.push_back(core_data_in);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        pin_data_in = b;
        pin_strobe  = 1'b1;
        repeat (4) @(negedge clk);
        pin_strobe = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] host strobe 0x%02h status=%b", b, pin_status);
    endtask

    task automatic send_header(input logic [7:0] b0, input logic [7:0] a2,
                               input logic [7:0] a1, input logic [7:0] a0,
                               input logic [7:0] l);
        send_byte(b0);
        send_byte(a2);
        send_byte(a1);
        send_byte(a0);
        send_byte(l);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        pin_rd = 1'b1;
        repeat (4) @(negedge clk);
        pin_rd = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] host rd out=0x%02h status=%b", pin_data_out, pin_status);
    endtask

    task automatic core_push(input logic [7:0] d);
        @(negedge clk);
        core_data_out   = d;
        core_data_valid = 1'b1;
        @(negedge clk);
        core_data_valid = 1'b0;
        $display("[TB] core push 0x%02h ready=%b", d, core_data_ready);
    endtask

    task automatic wait_ack_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (core_ack_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        core_ack_valid = 1'b1;
        @(negedge clk);
        core_ack_valid = 1'b0;
        $display("[TB] core ack status=%b", pin_status);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({pin_status, core_valid_in, core_ack_ready, core_data_ready} !== 7'b0000_001) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got status=%b vin=%b ackr=%b dready=%b, want 0000 0 0 1",
                     pin_status, core_valid_in, core_ack_ready, core_data_ready);
        end
        tests_run++;
        if ({addr, pin_data_out, core_data_in} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h out=%h cin=%h, want 0", addr, pin_data_out, core_data_in);
        end
    endtask

    task automatic test_frame();
        bit ok;
        logic [7:0] exp[$] = '{8'h11, 8'h22, 8'h33};
        core_ready_in = 1'b1;
        core_rx.delete();
        send_header(8'hC8, 8'h12, 8'h34, 8'h56, 8'h02);
        tests_run++;
        if ({opcode, source_id, dest_id, encdec, addr} !== {2'd3, 2'd0, 2'd2, 1'b0, 24'h123456}) begin
            tests_failed++;
            $display("FAIL frame_hdr: got op=%0d src=%0d dst=%0d ed=%0d addr=%h, want 3 0 2 0 123456",
                     opcode, source_id, dest_id, encdec, addr);
        end
        foreach (exp[i]) send_byte(exp[i]);
        wait_ack_ready(ok);
        tests_run++;
        if (!ok || core_rx.size() != 3 || core_rx[0] !== 8'h11 || core_rx[1] !== 8'h22 || core_rx[2] !== 8'h33) begin
            tests_failed++;
            $display("FAIL frame_payload: got ackr=%b n=%0d, want ackr=1 bytes 11 22 33", ok, core_rx.size());
        end
        do_ack();
        tests_run++;
        if ({pin_status[3:2], core_ack_ready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL frame_done: got err=%b done=%b ackr=%b, want 0 1 0",
                     pin_status[3], pin_status[2], core_ack_ready);
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        bit bad;
        logic [7:0] b0, a2, a1, a0, l, d;
        logic [7:0] exp[$];
        int exp_addr;
        for (int f = 0; f < 6; f++) begin
            b0 = 8'($urandom); a2 = 8'($urandom); a1 = 8'($urandom); a0 = 8'($urandom);
            l  = 8'($urandom_range(0, 5));
            exp.delete();
            core_rx.delete();
            core_ready_in = 1'b1;
            send_header(b0, a2, a1, a0, l);
            for (int i = 0; i <= int'(l); i++) begin
                d = 8'($urandom);
                exp.push_back(d);
                send_byte(d);
            end
            exp_addr = int'(a2) * 65536 + int'(a1) * 256 + int'(a0);
            tests_run++;
            if (int'(opcode) != int'(b0) / 64 || int'(source_id) != (int'(b0) / 16) % 4 ||
                int'(dest_id) != (int'(b0) / 4) % 4 || int'(encdec) != (int'(b0) / 2) % 2 ||
                int'(addr) != exp_addr) begin
                tests_failed++;
                $display("FAIL rand_hdr[%0d]: got op=%0d src=%0d dst=%0d ed=%0d addr=%h, want from b0=%h addr=%h",
                         f, opcode, source_id, dest_id, encdec, addr, b0, exp_addr);
            end
            wait_ack_ready(ok);
            bad = !ok || core_rx.size() != exp.size();
            if (!bad) foreach (exp[i]) if (core_rx[i] !== exp[i]) bad = 1'b1;
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL rand_payload[%0d]: got ackr=%b n=%0d, want ackr=1 n=%0d",
                         f, ok, core_rx.size(), exp.size());
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_ack();
            tests_run++;
            if (pin_status[3:2] !== 2'b01) begin
                tests_failed++;
                $display("FAIL rand_done[%0d]: got err/done=%b, want 01", f, pin_status[3:2]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] exp[$];
        core_ready_in = 1'b0;
        core_rx.delete();
        send_header(8'h44, 8'h00, 8'h00, 8'h01, 8'h07);
        for (int i = 0; i < 4; i++) begin
            exp.push_back(8'(8'hB0 + i));
            send_byte(8'(8'hB0 + i));
        end
        tests_run++;
        if (pin_status[3] !== 1'b0 || pin_status[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_full: got err=%b in_full=%b, want 0 1", pin_status[3], pin_status[0]);
        end
        send_byte(8'hEE);
        tests_run++;
        if (pin_status[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_err: got err=%b, want 1", pin_status[3]);
        end
        core_ready_in = 1'b1;
        repeat (8) @(negedge clk);
        ok = (core_rx.size() == 4);
        if (ok) foreach (exp[i]) if (core_rx[i] !== exp[i]) ok = 1'b0;
        tests_run++;
        if (!ok || core_ack_ready !== 1'b0 || pin_status[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: got n=%0d ackr=%b in_full=%b, want n=4 B0..B3 ackr=0 in_full=0",
                     core_rx.size(), core_ack_ready, pin_status[0]);
        end
        apply_reset();
    endtask

    task automatic test_out_fifo();
        logic [7:0] model[$];
        logic [7:0] d;
        core_push(8'hA1);
        core_push(8'hA2);
        repeat (3) @(negedge clk);
        tests_run++;
        if (pin_data_out !== 8'hA1 || pin_status[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL out_head: got %h valid=%b, want A1 1", pin_data_out, pin_status[1]);
        end
        pulse_rd();
        tests_run++;
        if (pin_data_out !== 8'hA2) begin
            tests_failed++;
            $display("FAIL out_pop1: got %h, want A2", pin_data_out);
        end
        pulse_rd();
        pulse_rd();
        tests_run++;
        if (pin_status[1] !== 1'b0 || pin_data_out !== 8'h00 || core_data_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL out_empty: got valid=%b out=%h ready=%b, want 0 00 1",
                     pin_status[1], pin_data_out, core_data_ready);
        end
        // Randomized push/read traffic against a queue model; pushes beyond depth are refused.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                core_push(d);
                if (model.size() < 4) model.push_back(d);
            end else begin
                pulse_rd();
                if (model.size() > 0) void'(model.pop_front());
            end
            @(negedge clk);
            tests_run++;
            if (pin_status[1] !== (model.size() > 0) || core_data_ready !== (model.size() < 4) ||
                pin_data_out !== (model.size() > 0 ? model[0] : 8'h00)) begin
                tests_failed++;
                $display("FAIL out_rand[%0d]: got out=%h valid=%b ready=%b, want out=%h n=%0d",
                         k, pin_data_out, pin_status[1], core_data_ready,
                         model.size() > 0 ? model[0] : 8'h00, model.size());
            end
        end
        while (model.size() > 0) begin
            pulse_rd();
            void'(model.pop_front());
        end
        for (int i = 0; i < 4; i++) core_push(8'(8'hC0 + i));
        tests_run++;
        if (core_data_ready !== 1'b0 || pin_data_out !== 8'hC0) begin
            tests_failed++;
            $display("FAIL out_full: got ready=%b out=%h, want 0 C0", core_data_ready, pin_data_out);
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        core_ready_in = 1'b0;
        send_header(8'h80, 8'hAA, 8'hBB, 8'hCC, 8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        apply_reset();
        tests_run++;
        if ({pin_status, core_valid_in, core_ack_ready, core_data_ready, addr} !== {7'b0000_001, 24'h0}) begin
            tests_failed++;
            $display("FAIL mid_reset: got status=%b vin=%b ackr=%b dready=%b addr=%h, want cleared",
                     pin_status, core_valid_in, core_ack_ready, core_data_ready, addr);
        end
        core_rx.delete();
        core_ready_in = 1'b1;
        send_header(8'h14, 8'h01, 8'h02, 8'h03, 8'h01);
        send_byte(8'h5A);
        send_byte(8'hA5);
        wait_ack_ready(ok);
        tests_run++;
        if (!ok || core_rx.size() != 2 || core_rx[0] !== 8'h5A || core_rx[1] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL mid_newframe: got ackr=%b n=%0d, want ackr=1 bytes 5A A5", ok, core_rx.size());
        end
        do_ack();
        tests_run++;
        if (pin_status[3:2] !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_done: got err/done=%b, want 01", pin_status[3:2]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        core_ready_in = 1'b0;
        core_rx.delete();
        send_header(8'h20, 8'h00, 8'h00, 8'h00, 8'h01);
        send_byte(8'h77);
        repeat (40) @(negedge clk);
`ifdef AES_BRIDGE_TIMEOUT_EN
        tests_run++;
        if (pin_status[3] !== 1'b1 || core_valid_in !== 1'b0 || core_ack_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_timeout: got err=%b vin=%b ackr=%b, want 1 0 0",
                     pin_status[3], core_valid_in, core_ack_ready);
        end
        send_byte(8'h00);
        tests_run++;
        if (pin_status[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_idle: got err=%b after new header byte, want 0", pin_status[3]);
        end
        apply_reset();
`else
        tests_run++;
        if (pin_status[3] !== 1'b0 || core_valid_in !== 1'b1 || core_ack_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold: got err=%b vin=%b ackr=%b, want 0 1 0",
                     pin_status[3], core_valid_in, core_ack_ready);
        end
        core_ready_in = 1'b1;
        send_byte(8'h78);
        wait_ack_ready(ok);
        tests_run++;
        if (!ok || core_rx.size() != 2 || core_rx[0] !== 8'h77 || core_rx[1] !== 8'h78) begin
            tests_failed++;
            $display("FAIL stall_resume: got ackr=%b n=%0d, want ackr=1 bytes 77 78", ok, core_rx.size());
        end
        do_ack();
`endif
    endtask

    initial begin
        rst = 1'b1;
        pin_data_in = '0;
        pin_strobe = 1'b0;
        pin_rd = 1'b0;
        core_ready_in = 1'b0;
        core_data_out = '0;
        core_data_valid = 1'b0;
        core_ack_valid = 1'b0;
        test_reset();
        test_frame();
        test_random_frames();
        test_backpressure();
        test_out_fifo();
        test_reset_mid_stream();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
